// File: rtl/sm2_mult_serial_pkg.sv
// Shared constants and FSM encoding for the SM2 digit-serial multiplier.
// The state encodings match the ones used by the fast-reduction stage.
package sm2_mult_serial_pkg;

    localparam int SM2_WIDTH = 256;
    localparam int SM2_DIGIT = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : sm2_mult_serial_pkg

// File: rtl/sm2_mac_digit.sv
// Combinational WIDTH x DIGIT multiply plus WIDTH-bit add: sum = acc + a*d.
// Kept separate so it can later be pipelined or mapped onto DSP blocks.
module sm2_mac_digit #(
    parameter int WIDTH = 256,
    parameter int DIGIT = 64
) (
    input  logic [WIDTH-1:0]       acc,
    input  logic [WIDTH-1:0]       a,
    input  logic [DIGIT-1:0]       d,
    output logic [WIDTH+DIGIT-1:0] sum
);

    // acc + a*d <= (2^W-1) + (2^W-1)(2^D-1) = 2^(W+D) - 2^D, so W+D bits never overflow.
    assign sum = {{DIGIT{1'b0}}, a} * {{WIDTH{1'b0}}, d} + {{DIGIT{1'b0}}, acc};

endmodule : sm2_mac_digit

// File: rtl/sm2_mult_serial.sv
// Digit-serial unsigned multiplier, WIDTH x WIDTH -> 2*WIDTH, one DIGIT of b per cycle.
// Valid/ready on both sides; holds a single operation at a time.
module sm2_mult_serial
    import sm2_mult_serial_pkg::*;
#(
    parameter int WIDTH = SM2_WIDTH,
    parameter int DIGIT = SM2_DIGIT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int LO_W  = WIDTH - DIGIT;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   acc_hi;
    logic [LO_W-1:0]    lo;
    logic [WIDTH+DIGIT-1:0] sum;
    logic [WIDTH-1:0]   lo_next;
    logic               accept;
    logic               last;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;
    assign last     = (cnt == CNT_W'(NDIG - 1));

    // The lowest DIGIT bits of lo would be shifted out before use, so only the upper part is stored.
    assign lo_next = {sum[DIGIT-1:0], lo};

    // b_r shifts right each MUL cycle, so its low digit is always the current one (LSB first).
    sm2_mac_digit #(
        .WIDTH(WIDTH),
        .DIGIT(DIGIT)
    ) u_mac (
        .acc(acc_hi),
        .a  (a_r),
        .d  (b_r[DIGIT-1:0]),
        .sum(sum)
    );

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_next = state;
        unique case (state)
            IDLE:    if (accept) state_next = MUL;
            MUL:     if (last) state_next = DONE;
            DONE:    if (out_valid && out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all registers update together.
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            a_r       <= '0;
            b_r       <= '0;
            acc_hi    <= '0;
            lo        <= '0;
            out_valid <= 1'b0;
            product   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        a_r    <= a;
                        b_r    <= b;
                        acc_hi <= '0;
                        lo     <= '0;
                        cnt    <= '0;
                    end
                end
                MUL: begin
                    b_r    <= b_r >> DIGIT;
                    acc_hi <= sum[WIDTH+DIGIT-1:DIGIT];
                    lo     <= lo_next[WIDTH-1:DIGIT];
                    cnt    <= cnt + CNT_W'(1);
                    if (last) begin
                        product   <= {sum[WIDTH+DIGIT-1:DIGIT], lo_next};
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: out_valid <= 1'b0;
            endcase
        end
    end

endmodule : sm2_mult_serial
